// File: rtl/image_stream_feeder_if.sv
// Control, buffer-write and pixel-stream signals of the image stream feeder.
// The feeder itself sits on the slave side; the host/consumer side is master.
interface image_stream_feeder_if #(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 24
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              start;
  logic              conv_complete;
  logic              conv_start;
  logic [PIX_W-1:0]  d_out;
  logic              image_input_ready;
  logic              busy;
  logic              done;
  logic              timeout;

  modport master (
    output wr_en, wr_addr, wr_data, start, conv_complete,
    input  conv_start, d_out, image_input_ready, busy, done, timeout
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, conv_complete,
    output conv_start, d_out, image_input_ready, busy, done, timeout
  );
endinterface

// File: rtl/image_stream_feeder.sv
// Image buffer plus raster-order pixel streamer feeding the first conv layer:
// kick, stream with prefill-qualified ready, zero-pad until completion or timeout.
module image_stream_feeder #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int PIX_W     = 24,
  parameter int ADDR_W    = 10,
  parameter int PREFILL   = 84,
  parameter int FLUSH_MAX = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  image_stream_feeder_if.slave bus
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int FCNT_W = $clog2(FLUSH_MAX + 1);

  localparam logic [ADDR_W-1:0] LAST_PIX    = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] PREFILL_CNT = ADDR_W'(PREFILL);
  localparam logic [FCNT_W-1:0] FLUSH_LIMIT = FCNT_W'(FLUSH_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KICK   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [FCNT_W-1:0] r_flush_cnt;
  logic [PIX_W-1:0]  r_rd_data;
  logic [PIX_W-1:0]  r_mem [NPIX];

  logic [1:0]        w_next_state;
  logic              w_done;
  logic              w_timeout;
  logic              w_wr_ok;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_KICK;
      end
      S_KICK: begin
        w_next_state = S_STREAM;
      end
      S_STREAM: begin
        if (bus.conv_complete) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_pix_cnt == LAST_PIX) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bus.conv_complete) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_flush_cnt == FLUSH_LIMIT) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pix_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pix_cnt   <= (r_state == S_STREAM && w_next_state == S_STREAM)
                     ? r_pix_cnt + 1'b1 : '0;
      r_flush_cnt <= (r_state == S_FLUSH && w_next_state == S_FLUSH)
                     ? r_flush_cnt + 1'b1 : '0;
    end
  end

  // Read one pixel ahead so pixel n is on d_out while the counter equals n.
  assign w_rd_addr = (r_state == S_KICK) ? '0 : r_pix_cnt + 1'b1;
  assign w_rd_en   = (r_state == S_KICK) ||
                     (r_state == S_STREAM && r_pix_cnt != LAST_PIX);
  assign w_wr_ok   = (r_state == S_IDLE) && bus.wr_en &&
                     (int'(bus.wr_addr) < NPIX);

  // NOTE: the pixel buffer and its read register carry no reset; contents must
  // survive reset, and d_out is gated by state so stale read data never leaks.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
  end

  assign bus.conv_start        = (r_state == S_KICK);
  assign bus.d_out             = (r_state == S_STREAM) ? r_rd_data : '0;
  assign bus.image_input_ready = ((r_state == S_STREAM && r_pix_cnt >= PREFILL_CNT) ||
                                  (r_state == S_FLUSH)) && !w_done && !w_timeout;
  assign bus.busy              = (r_state != S_IDLE);
  assign bus.done              = w_done;
  assign bus.timeout           = w_timeout;

endmodule

// File: tb/tb_image_stream_feeder.sv
// Self-checking bench: offset-based behavioural model compared every cycle,
// directed test-plan scenarios with literal expectations, then random runs.
module tb_image_stream_feeder;
  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int PIX_W     = 24;
  localparam int ADDR_W    = 10;
  localparam int PREFILL   = 84;
  localparam int FLUSH_MAX = 64;
  localparam int NPIX      = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  image_stream_feeder_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  image_stream_feeder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
    .PREFILL(PREFILL), .FLUSH_MAX(FLUSH_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int s     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, bus.conv_start, bus.image_input_ready, bus.busy,
            bus.done, bus.timeout, bus.d_out};
  endfunction

  // Behavioural model: the stream is a timeline indexed by k cycles after the
  // start sample; k=1 is the kick, k=2+n shows pixel n, then flush cycles.
  logic [PIX_W-1:0] m_mem [NPIX];
  bit m_on  = 1'b0;
  int m_k   = 0;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic             e_cs, e_rdy, e_busy, e_done, e_to;
      logic [PIX_W-1:0] e_d;
      logic [ADDR_W-1:0] idx;
      bit fin;
      int j;
      e_cs = 0; e_rdy = 0; e_busy = 0; e_done = 0; e_to = 0; e_d = '0; fin = 0;
      if (m_on) begin
        e_busy = 1;
        if (m_k == 1) begin
          e_cs = 1;
        end else if (m_k <= NPIX + 1) begin
          idx = ADDR_W'(m_k - 2);
          e_d = m_mem[idx];
          if (bus.conv_complete) begin e_done = 1; fin = 1; end
          else e_rdy = (m_k - 2 >= PREFILL);
        end else begin
          j = m_k - NPIX - 2;
          if (bus.conv_complete) begin e_done = 1; fin = 1; end
          else if (j == FLUSH_MAX) begin e_to = 1; fin = 1; end
          else e_rdy = 1;
        end
      end
      check("cycle_outputs", outs(), {3'b0, e_cs, e_rdy, e_busy, e_done, e_to, e_d});
      if (!m_on && bus.wr_en && int'(bus.wr_addr) < NPIX) m_mem[bus.wr_addr] = bus.wr_data;
      if (!rst) m_on = 0;
      else if (m_on) begin
        if (fin) m_on = 0;
        else m_k++;
      end else if (bus.start) begin
        m_on = 1;
        m_k  = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s++;
  endtask

  task automatic go_to(input int t);
    while (s < t) tick();
  endtask

  task automatic start_stream();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    s = 1;
  endtask

  task automatic clear_inputs();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 0; bus.conv_complete = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin tick(); n++; end
    check("idle_within_budget", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, budget;
    clear_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    check("reset_outputs", outs(), 32'd0);

    // Load pixel value = raster index.
    for (int i = 0; i < NPIX; i++) begin
      bus.wr_en = 1; bus.wr_addr = ADDR_W'(i); bus.wr_data = PIX_W'(i);
      tick();
    end
    bus.wr_en = 0;
    tick();

    // Full stream, completion during flush.
    start_stream();
    #1 check("kick_conv_start", {31'b0, bus.conv_start}, 32'd1);
    go_to(2);  #1 check("pix0_data", {8'b0, bus.d_out}, 32'd0);
    check("pix0_ready", {31'b0, bus.image_input_ready}, 32'd0);
    go_to(85); #1 check("pix83_ready", {31'b0, bus.image_input_ready}, 32'd0);
    go_to(86); #1 check("pix84_ready", {31'b0, bus.image_input_ready}, 32'd1);
    check("pix84_data", {8'b0, bus.d_out}, 32'd84);
    go_to(785); #1 check("pix783_data", {8'b0, bus.d_out}, 32'd783);
    go_to(786); #1 check("flush_data", {8'b0, bus.d_out}, 32'd0);
    check("flush_ready", {31'b0, bus.image_input_ready}, 32'd1);
    go_to(820);
    bus.conv_complete = 1;
    #1 check("flush_done", {30'b0, bus.done, bus.image_input_ready}, 32'd2);
    tick();
    bus.conv_complete = 0;
    #1 check("after_done", outs(), 32'd0);
    tick();

    // No completion: timeout after FLUSH_MAX flush cycles.
    start_stream();
    go_to(786 + FLUSH_MAX - 1);
    #1 check("pre_timeout", {30'b0, bus.timeout, bus.image_input_ready}, 32'd1);
    go_to(786 + FLUSH_MAX);
    #1 check("timeout_pulse", {29'b0, bus.timeout, bus.done, bus.image_input_ready}, 32'd4);
    tick();
    #1 check("after_timeout", outs(), 32'd0);

    // Early completion at pixel 300.
    start_stream();
    go_to(302);
    bus.conv_complete = 1;
    #1 check("early_done", {bus.done, 7'b0, bus.d_out}, {1'b1, 7'b0, 24'd300});
    tick();
    bus.conv_complete = 0;
    #1 check("early_after", {bus.image_input_ready, 7'b0, bus.d_out}, 32'd0);
    bus.wr_en = 1; bus.wr_addr = 10'd5; bus.wr_data = 24'hABCDEF;
    tick();
    bus.wr_en = 0;

    // Restart; writes and extra starts during the stream are ignored.
    start_stream();
    go_to(7);  #1 check("pix5_new", {8'b0, bus.d_out}, 32'h00ABCDEF);
    bus.wr_en = 1; bus.wr_addr = 10'd10; bus.wr_data = 24'h123456;
    bus.start = 1;
    tick();
    bus.wr_en = 0;
    go_to(9);  #1 check("no_restart_kick", {31'b0, bus.conv_start}, 32'd0);
    bus.start = 0;
    go_to(12); #1 check("pix10_kept", {8'b0, bus.d_out}, 32'd10);
    go_to(500);
    bus.conv_complete = 1;
    tick();
    bus.conv_complete = 0;

    // Reset mid-stream, then the original buffer streams again.
    start_stream();
    go_to(402);
    rst = 0;
    tick();
    #1 check("reset_mid_stream", outs(), 32'd0);
    rst = 1;
    tick();
    start_stream();
    go_to(2);  #1 check("post_rst_pix0", {8'b0, bus.d_out}, 32'd0);
    go_to(7);  #1 check("post_rst_pix5", {8'b0, bus.d_out}, 32'h00ABCDEF);
    go_to(12); #1 check("post_rst_pix10", {8'b0, bus.d_out}, 32'd10);
    wait_idle(1000);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        bus.wr_en = 1;
        bus.wr_addr = ADDR_W'($urandom_range(0, 1023));
        bus.wr_data = PIX_W'($urandom);
        tick();
      end
      bus.wr_en = ($urandom_range(0, 1) == 1);
      bus.wr_addr = ADDR_W'($urandom_range(0, NPIX - 1));
      bus.wr_data = PIX_W'($urandom);
      start_stream();
      bus.wr_en = 0;
      case (r % 4)
        0: p = 0;
        1: p = 2;
        2: p = 10;
        default: p = 100;
      endcase
      budget = 0;
      while (bus.busy && budget < 2000) begin
        rst = ($urandom_range(0, 2999) != 0);
        bus.conv_complete = ($urandom_range(0, 9999) < p);
        bus.start = ($urandom_range(0, 15) == 0);
        bus.wr_en = ($urandom_range(0, 7) == 0);
        bus.wr_addr = ADDR_W'($urandom_range(0, 1023));
        bus.wr_data = PIX_W'($urandom);
        tick();
        budget++;
      end
      rst = 1;
      clear_inputs();
      check("random_run_ends", {31'b0, bus.busy}, 32'd0);
      tick();
    end

    clear_inputs();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
